fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction fetch for the AGC pipeline, directly upstream of decode, register_file and stall_logic.
//  Holds the software PC and issues fixed-memory read addresses through the external
//  addr_translate_ROM to a synchronous-read ROM. Delivers 15-bit words plus PC to decode.
//  Absorbs EXTEND prefix words (15'o00006) and marks the following instruction as extended.
//  Honours stall from stall_logic and flush/redirect from branching_logic.
// PARAMETERS
//  RESET_PC   12'o4000   software address of first fetch after reset
//  EXTEND_OP  15'o00006  encoding of the EXTEND prefix word
// PORTS
//  clk          in   1   clock, all state on posedge
//  rst          in   1   reset: synchronous, active-high
//  stall        in   1   decode cannot accept; hold outputs, stop issuing
//  flush        in   1   branch taken in E; discard in-flight work, refetch at redirect_pc
//  redirect_pc  in   12  software target address, valid while flush=1
//  rom_en       out  1   ROM read strobe this cycle
//  rom_addr     out  12  software address to translate and read
//  rom_rdata    in   15  ROM word; valid the cycle after rom_en=1
//  dec_valid    out  1   dec_* hold a real instruction
//  dec_instr    out  15  instruction word
//  dec_pc       out  12  software address of dec_instr
//  dec_extend   out  1   dec_instr was preceded by EXTEND
// BEHAVIOUR
//  Reset: pc_q=RESET_PC; dec_valid=0; dec_instr=0; dec_pc=0; dec_extend=0;
//   skid, in-flight and extend_pending flags cleared; rom_en=0 while rst=1.
//   Reset mid-operation drops every in-flight word with no output.
//  Issue (combinational): rom_en=flush|~stall; rom_addr=flush?redirect_pc:pc_q.
//   On issue: pc_q<=rom_addr+1, mod 4096 (12'o7777 wraps to 0).
//   inflight_v<=1 and inflight_pc<=rom_addr. No issue: pc_q holds, inflight_v<=0.
//  Latency: address issued in cycle t -> rom_rdata in t+1 -> dec_* registered, visible t+2.
//  Return (cycle with inflight_v=1 and no flush): word w with address inflight_pc.
//   If w==EXTEND_OP: word consumed, extend_pending<=1, nothing delivered.
//    Consecutive EXTENDs leave extend_pending=1.
//   Else if ~stall and skid empty: dec_*<={1,w,inflight_pc,extend_pending}; extend_pending<=0.
//   Else: word, pc and the extend flag go into the 1-entry skid; extend_pending<=0.
//  Stall: dec_* hold their values exactly. At most one word returns during a stall,
//   so the skid never overflows.
//  Drain: first cycle with stall=0 and skid full: dec_*<=skid contents, skid empties.
//   The same cycle issues pc_q; its word arrives next cycle with the skid empty.
//  Idle: stall=0, no return and skid empty -> dec_valid<=0.
//  Flush (priority over stall): clears skid, extend_pending and dec_valid.
//   The word returning in the flush cycle is discarded, including an EXTEND.
//   Issues redirect_pc that same cycle; the first target instruction is on dec_* at t+2.
//  Simultaneous flush+rst: rst wins.
//  Ordering: instructions reach decode in address order, none duplicated or lost without flush.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined:
//   - adds out ports perf_fetched[31:0] (increments per word delivered on dec_*,
//     EXTEND excluded) and perf_flushed[31:0] (increments per flush cycle).
//   - both counters reset to 0 on rst and wrap at 2^32.
//  FETCH_PERF_CNT_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  - rst 3 cycles then release -> rom_addr=12'o4000 with rom_en=1 first cycle;
//    dec_pc=12'o4000 valid 2 cycles later; consecutive pcs 4001, 4002 follow.
//  - stall raised while 12'o4005 in flight, held 4 cycles -> dec_* frozen on 4004;
//    4005 delivered on first unstalled cycle; 4006 next; no gaps or duplicates.
//  - flush with redirect_pc=12'o2345 while 2 words pending -> dec_valid=0 next cycle;
//    dec_pc=12'o2345 two cycles after flush; discarded words never appear.
//  - ROM returns 15'o00006 at 4010, then 15'o30001 -> no output for 4010;
//    dec_instr=15'o30001, dec_pc=12'o4011, dec_extend=1; following instr dec_extend=0.
//  - EXTEND returned in same cycle as flush with stall=1 -> flush wins;
//    first target instr dec_extend=0.
//  - pc_q=12'o7777, no stall -> next issued rom_addr=12'o0000;
//    with FETCH_PERF_CNT_EN, perf_fetched matches count of delivered instrs.

Source files
------------

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch for the AGC pipeline, feeding decode. Holds the software
// PC, issues read addresses (through the external address translator) to a
// synchronous-read ROM, and delivers 15-bit instruction words with their PC.
// EXTEND prefix words are absorbed and flag the following instruction.
// A one-entry skid buffer catches the single word that can return while
// decode is stalled. Flush (branch redirect) has priority over stall.
//
// Ports
//   clk          in   1   clock, all state on posedge
//   rst          in   1   synchronous, active-high reset
//   stall        in   1   decode cannot accept; hold dec_*, stop issuing
//   flush        in   1   discard in-flight work, refetch at redirect_pc
//   redirect_pc  in   12  refetch target, valid while flush=1
//   rom_en       out  1   ROM read strobe this cycle
//   rom_addr     out  12  software address to read
//   rom_rdata    in   15  ROM word, valid the cycle after rom_en=1
//   dec_valid    out  1   dec_* hold a real instruction
//   dec_instr    out  15  instruction word
//   dec_pc       out  12  software address of dec_instr
//   dec_extend   out  1   dec_instr was preceded by EXTEND
//   perf_fetched out  32  words delivered on dec_* (FETCH_PERF_CNT_EN only)
//   perf_flushed out  32  flush cycles seen       (FETCH_PERF_CNT_EN only)
//
// Configuration
//   FETCH_PERF_CNT_EN : when defined, adds the two performance counters.
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [11:0] RESET_PC  = 12'o4000,
    parameter logic [14:0] EXTEND_OP = 15'o00006
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [11:0] redirect_pc,
    output logic        rom_en,
    output logic [11:0] rom_addr,
    input  logic [14:0] rom_rdata,
    output logic        dec_valid,
    output logic [14:0] dec_instr,
    output logic [11:0] dec_pc,
    output logic        dec_extend
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushed
`endif
);

    logic [11:0] pc_q, pc_d;
    logic        inflight_v_q, inflight_v_d;
    logic [11:0] inflight_pc_q, inflight_pc_d;
    logic        ext_pend_q, ext_pend_d;

    logic        skid_v_q, skid_v_d;
    logic [14:0] skid_instr_q, skid_instr_d;
    logic [11:0] skid_pc_q, skid_pc_d;
    logic        skid_ext_q, skid_ext_d;

    logic        dec_valid_q, dec_valid_d;
    logic [14:0] dec_instr_q, dec_instr_d;
    logic [11:0] dec_pc_q, dec_pc_d;
    logic        dec_extend_q, dec_extend_d;

    logic        ret_v;
    logic        ret_ext;
    logic        ret_word;
    logic        deliver;

    always_comb begin
        // Issue side: a flush always issues its target, even during a stall.
        rom_en        = ~rst & (flush | ~stall);
        rom_addr      = flush ? redirect_pc : pc_q;
        pc_d          = rom_en ? rom_addr + 12'd1 : pc_q;
        inflight_v_d  = rom_en;
        inflight_pc_d = rom_en ? rom_addr : inflight_pc_q;

        // Return side: the word answering last cycle's issue, unless flushed.
        ret_v    = inflight_v_q & ~flush;
        ret_ext  = ret_v & (rom_rdata == EXTEND_OP);
        ret_word = ret_v & ~ret_ext;

        ext_pend_d   = ext_pend_q;
        skid_v_d     = skid_v_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_ext_d   = skid_ext_q;
        dec_valid_d  = dec_valid_q;
        dec_instr_d  = dec_instr_q;
        dec_pc_d     = dec_pc_q;
        dec_extend_d = dec_extend_q;
        deliver      = 1'b0;

        if (flush) begin
            skid_v_d    = 1'b0;
            ext_pend_d  = 1'b0;
            dec_valid_d = 1'b0;
        end else begin
            if (ret_ext) begin
                ext_pend_d = 1'b1;
            end

            // The skid holds the oldest word, so it drains ahead of any return.
            if (!stall && skid_v_q) begin
                dec_valid_d  = 1'b1;
                dec_instr_d  = skid_instr_q;
                dec_pc_d     = skid_pc_q;
                dec_extend_d = skid_ext_q;
                skid_v_d     = 1'b0;
                deliver      = 1'b1;
            end else if (!stall && ret_word) begin
                dec_valid_d  = 1'b1;
                dec_instr_d  = rom_rdata;
                dec_pc_d     = inflight_pc_q;
                dec_extend_d = ext_pend_q;
                ext_pend_d   = 1'b0;
                deliver      = 1'b1;
            end else if (!stall) begin
                // Nothing new (including a consumed EXTEND): do not repeat.
                dec_valid_d = 1'b0;
            end

            if (ret_word && (stall || skid_v_q)) begin
                skid_v_d     = 1'b1;
                skid_instr_d = rom_rdata;
                skid_pc_d    = inflight_pc_q;
                skid_ext_d   = ext_pend_q;
                ext_pend_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            inflight_v_q <= 1'b0;
            ext_pend_q   <= 1'b0;
            skid_v_q     <= 1'b0;
            dec_valid_q  <= 1'b0;
            dec_instr_q  <= '0;
            dec_pc_q     <= '0;
            dec_extend_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            inflight_v_q <= inflight_v_d;
            ext_pend_q   <= ext_pend_d;
            skid_v_q     <= skid_v_d;
            dec_valid_q  <= dec_valid_d;
            dec_instr_q  <= dec_instr_d;
            dec_pc_q     <= dec_pc_d;
            dec_extend_q <= dec_extend_d;
        end
    end

    // Payload registers are qualified by their valid flags and need no reset.
    always_ff @(posedge clk) begin
        inflight_pc_q <= inflight_pc_d;
        skid_instr_q  <= skid_instr_d;
        skid_pc_q     <= skid_pc_d;
        skid_ext_q    <= skid_ext_d;
    end

    assign dec_valid  = dec_valid_q;
    assign dec_instr  = dec_instr_q;
    assign dec_pc     = dec_pc_q;
    assign dec_extend = dec_extend_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_flushed_q, perf_flushed_d;

    always_comb begin
        perf_fetched_d = perf_fetched_q + {31'd0, deliver};
        perf_flushed_d = perf_flushed_q + {31'd0, flush};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_flushed_q <= perf_flushed_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
`else
    logic unused_deliver;
    assign unused_deliver = deliver;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Drives fetch_stage against a ROM model. A reference model tracks fetched
// words as a queue of returned instructions in program order; decode takes
// the oldest one whenever it is not stalled. Directed steps cover reset,
// stall/skid, EXTEND, flush and PC wrap; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [14:0] EXT = 15'o00006;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic [11:0] redirect_pc;
    logic        rom_en;
    logic [11:0] rom_addr;
    logic [14:0] rom_rdata = '0;
    logic        dec_valid;
    logic [14:0] dec_instr;
    logic [11:0] dec_pc;
    logic        dec_extend;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_flushed;
`endif

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .redirect_pc(redirect_pc), .rom_en(rom_en), .rom_addr(rom_addr),
        .rom_rdata(rom_rdata), .dec_valid(dec_valid), .dec_instr(dec_instr),
        .dec_pc(dec_pc), .dec_extend(dec_extend)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`endif
    );

    logic [14:0] mem [0:4095];
    always @(posedge clk) if (rom_en) rom_rdata <= mem[rom_addr];

    typedef struct packed {
        logic [11:0] pc;
        logic [14:0] instr;
        logic        ext;
    } item_t;

    item_t       m_q[$];
    logic [11:0] m_pc = 12'o4000;
    logic        m_inf_v = 1'b0;
    logic [11:0] m_inf_pc = '0;
    logic        m_ext = 1'b0;
    logic        m_dv = 1'b0;
    logic [14:0] m_di = '0;
    logic [11:0] m_dp = '0;
    logic        m_de = 1'b0;
    logic [31:0] m_pf = '0, m_pfl = '0;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic f, input logic [11:0] rpc);
        logic        exp_en;
        logic [11:0] exp_addr;
        logic [14:0] w;
        item_t       it;
        rst = r; stall = s; flush = f; redirect_pc = rpc;
        #1;
        exp_en   = !r && (f || !s);
        exp_addr = f ? rpc : m_pc;
        chk("rom_en", {31'd0, rom_en}, {31'd0, exp_en});
        if (exp_en) chk("rom_addr", {20'd0, rom_addr}, {20'd0, exp_addr});
        @(posedge clk);
        #1;
        if (r) begin
            m_pc = 12'o4000; m_inf_v = 0; m_ext = 0; m_q.delete();
            m_dv = 0; m_di = 0; m_dp = 0; m_de = 0; m_pf = 0; m_pfl = 0;
        end else begin
            if (m_inf_v && !f) begin
                w = mem[m_inf_pc];
                if (w == EXT) m_ext = 1;
                else begin
                    it.pc = m_inf_pc; it.instr = w; it.ext = m_ext;
                    m_q.push_back(it);
                    m_ext = 0;
                end
            end
            if (f) begin
                m_q.delete(); m_ext = 0; m_dv = 0; m_pfl++;
            end else if (!s) begin
                if (m_q.size() > 0) begin
                    it = m_q.pop_front();
                    m_dv = 1; m_di = it.instr; m_dp = it.pc; m_de = it.ext;
                    m_pf++;
                end else begin
                    m_dv = 0;
                end
            end
            m_inf_v = exp_en;
            if (exp_en) begin
                m_inf_pc = exp_addr;
                m_pc     = exp_addr + 12'd1;
            end
        end
        chk("dec_valid",  {31'd0, dec_valid},  {31'd0, m_dv});
        chk("dec_instr",  {17'd0, dec_instr},  {17'd0, m_di});
        chk("dec_pc",     {20'd0, dec_pc},     {20'd0, m_dp});
        chk("dec_extend", {31'd0, dec_extend}, {31'd0, m_de});
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetched", perf_fetched, m_pf);
        chk("perf_flushed", perf_flushed, m_pfl);
`endif
    endtask

    initial begin
        logic [14:0] w;
        logic [11:0] a;
        logic r, s, f;
        rst = 1; stall = 0; flush = 0; redirect_pc = '0;
        for (int i = 0; i < 4096; i++) begin
            w = 15'($urandom);
            if (w == EXT) w = 15'o00007;
            mem[i] = w;
        end
        mem[12'o4010] = EXT;
        mem[12'o4011] = 15'o30001;
        mem[12'o2350] = EXT;

        // Reset
        repeat (3) step(1, 0, 0, 12'o0);
        chk("rst_valid", {31'd0, dec_valid}, 32'd0);
        chk("rst_pc", {20'd0, dec_pc}, 32'd0);

        // Sequential fetch: cycle 0 issues 4000, visible after cycle 1
        step(0, 0, 0, 12'o0);
        step(0, 0, 0, 12'o0);
        chk("first_valid", {31'd0, dec_valid}, 32'd1);
        chk("first_pc", {20'd0, dec_pc}, {20'd0, 12'o4000});
        step(0, 0, 0, 12'o0);
        chk("second_pc", {20'd0, dec_pc}, {20'd0, 12'o4001});
        step(0, 0, 0, 12'o0);
        chk("third_pc", {20'd0, dec_pc}, {20'd0, 12'o4002});
        step(0, 0, 0, 12'o0);
        step(0, 0, 0, 12'o0);

        // Stall with 4005 in flight
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 12'o0);
            chk("stall_hold_pc", {20'd0, dec_pc}, {20'd0, 12'o4004});
        end
        step(0, 0, 0, 12'o0);
        chk("drain_pc", {20'd0, dec_pc}, {20'd0, 12'o4005});
        step(0, 0, 0, 12'o0);
        chk("after_drain_pc", {20'd0, dec_pc}, {20'd0, 12'o4006});
        step(0, 0, 0, 12'o0);
        chk("pc_4007", {20'd0, dec_pc}, {20'd0, 12'o4007});

        // EXTEND at 4010 is absorbed
        step(0, 0, 0, 12'o0);
        chk("ext_absorbed", {31'd0, dec_valid}, 32'd0);
        step(0, 0, 0, 12'o0);
        chk("ext_pc", {20'd0, dec_pc}, {20'd0, 12'o4011});
        chk("ext_instr", {17'd0, dec_instr}, {17'd0, 15'o30001});
        chk("ext_flag", {31'd0, dec_extend}, 32'd1);
        step(0, 0, 0, 12'o0);
        chk("ext_next_flag", {31'd0, dec_extend}, 32'd0);

        // Flush with a word in the skid
        step(0, 1, 0, 12'o0);
        step(0, 1, 1, 12'o2345);
        chk("flush_valid", {31'd0, dec_valid}, 32'd0);
        step(0, 0, 0, 12'o0);
        chk("target_pc", {20'd0, dec_pc}, {20'd0, 12'o2345});
        step(0, 0, 0, 12'o0);
        step(0, 0, 0, 12'o0);

        // EXTEND (2350) returns in a stalled flush cycle
        step(0, 1, 1, 12'o1234);
        step(0, 0, 0, 12'o0);
        chk("flush_ext_pc", {20'd0, dec_pc}, {20'd0, 12'o1234});
        chk("flush_ext_flag", {31'd0, dec_extend}, 32'd0);

        // PC wrap
        step(0, 0, 1, 12'o7776);
        step(0, 0, 0, 12'o0);
        step(0, 0, 0, 12'o0);
        step(0, 0, 0, 12'o0);
        chk("wrap_pc", {20'd0, dec_pc}, 32'd0);

        // Randomized phase with EXTENDs sprinkled through the ROM
        step(1, 0, 0, 12'o0);
        step(1, 0, 0, 12'o0);
        for (int k = 0; k < 200; k++) begin
            a = 12'($urandom);
            mem[a] = EXT;
            if (k % 4 == 0) mem[a + 12'd1] = EXT;
        end
        mem[12'o7777] = EXT;
        for (int c = 0; c < 3000; c++) begin
            r = ($urandom_range(0, 199) == 0);
            s = ($urandom_range(0, 99) < 30);
            f = ($urandom_range(0, 99) < 6);
            step(r, s, f, 12'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
